uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel UART receiver. Consumes the 16x-oversample tick from the
//  baud-rate generator and the asynchronous rx line, recovers one 8N1 frame
//  (LSB first), presents the byte and flags framing errors.
//  Sits between the board rx pin and the byte consumer (FIFO / command parser).
// PARAMETERS
//  DBITS       8   data bits per frame
//  OVERSAMPLE  16  sample ticks per bit period; must be even and >= 4
//  SB_TICK     16  ticks spent in stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2)
// PORTS
//  clk           in   1      system clock; sole clock domain
//  reset         in   1      asynchronous, active-high reset
//  sample_tick   in   1      1-cycle strobe, OVERSAMPLE per bit, from baud gen
//  rx            in   1      asynchronous serial input; idles high
//  data_out      out  DBITS  last received byte; held until next rx_done_tick
//  rx_done_tick  out  1      1-cycle pulse; data_out/frame_error valid with it
//  frame_error   out  1      stop bit sampled low on last frame; held until next done
// BEHAVIOUR
//  - Reset (async, high): state=IDLE, counters=0, shift reg=0, data_out=0,
//    rx_done_tick=0, frame_error=0, both synchroniser flops=1 (line idle).
//  - rx passes a 2-flop synchroniser; FSM sees only rx_s (2-cycle latency).
//  - Tick counter s: width clog2(max(OVERSAMPLE,SB_TICK)); bit counter n:
//    width clog2(DBITS). Both advance only on cycles with sample_tick=1.
//  - FSM states IDLE, START, DATA, STOP:
//    IDLE : rx_s==0 -> START, s=0 (no tick needed to leave IDLE).
//    START: on tick, s==OVERSAMPLE/2-1: rx_s==0 -> DATA, s=0, n=0;
//           rx_s==1 -> IDLE (glitch rejected, no outputs change); else s++.
//    DATA : on tick, s==OVERSAMPLE-1: shreg={rx_s,shreg[DBITS-1:1]}, s=0;
//           n==DBITS-1 -> STOP, else n++; otherwise s++.
//    STOP : on tick, s==SB_TICK-1: data_out<=shreg, frame_error<=~rx_s,
//           rx_done_tick<=1 next cycle, -> IDLE; otherwise s++.
//  - Sampling point is mid-bit; rx_done_tick registered, asserted the clk
//    cycle after the final stop-bit tick, high exactly one cycle.
//  - Framing error still delivers the byte (done pulses, frame_error=1).
//  - Line held low (break): frame with data 0x00, frame_error=1, then IDLE
//    immediately re-enters START; repeats while low. Accepted behaviour.
//  - sample_tick=0 freezes s/n/state (except IDLE->START edge detect).
//  - Back-to-back frames: new start bit accepted in IDLE the cycle after STOP
//    exits; no idle gap required.
//  - Reset mid-frame: frame discarded, no rx_done_tick, outputs to reset values.
// STRUCTURE
//  - uart_pkg: state enum encoding (IDLE=0,START=1,DATA=2,STOP=3), shared
//    default OVERSAMPLE/DBITS constants used by rx, tx and baud generator.
//  - Sub-module sync_2ff (1-bit, reset value parameter) for rx; FSM, counters
//    and shift register stay in uart_receiver. Baud generator instantiated at
//    top level, not inside this block.
// TESTING (bench: baud gen with M=4 -> tick every 4 clk, bit = 64 clk)
//  1. Idle high, send 0xA5 8N1 -> one rx_done_tick, data_out=0xA5, frame_error=0.
//  2. rx low for 5 ticks then high (< OVERSAMPLE/2) -> back to IDLE, no done,
//     data_out unchanged.
//  3. Send 0x3C with stop bit driven low -> done pulse, data_out=0x3C,
//     frame_error=1; next clean frame 0x11 -> frame_error returns 0.
//  4. Assert reset during data bit 3 of 0xFF -> data_out=0, no done; after
//     release send 0x5A -> data_out=0x5A, single done pulse.
//  5. Back-to-back 0x00 then 0xFF, zero idle gap -> exactly two done pulses,
//     values 0x00 then 0xFF, frame_error=0 both.
//  6. Hold sample_tick=0, wiggle rx after start detect -> state/counters
//     frozen; resume ticks with valid frame 0x81 -> data_out=0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default frame
// geometry used by the receiver, transmitter and baud generator.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DEF_DBITS      = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_SB_TICK    = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width helper that never collapses to zero bits.
  function automatic int cnt_width(input int count);
    return max_int(1, $clog2(count));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; RESET_VAL sets the
// value both flops take while reset is asserted.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1-style UART receiver driven by an external oversample tick. Recovers one
// frame LSB first, samples mid-bit and reports framing errors with the byte.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DBITS      = DEF_DBITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int SB_TICK    = DEF_SB_TICK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic             rx,
  output logic [DBITS-1:0] data_out,
  output logic             rx_done_tick,
  output logic             frame_error,
  output uart_state_e      state_dbg
);

  localparam int SW = cnt_width(max_int(OVERSAMPLE, SB_TICK));
  localparam int NW = cnt_width(DBITS);

  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBITS - 1);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_receiver: OVERSAMPLE must be even and >= 4");
  end
  if (SB_TICK < 1 || DBITS < 1) begin : g_bad_geometry
    $error("uart_receiver: SB_TICK and DBITS must be positive");
  end

  logic rx_s;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  uart_state_e      state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [NW-1:0]    n_q, n_d;
  logic [DBITS-1:0] shreg_q, shreg_d;
  logic [DBITS-1:0] data_q, data_d;
  logic             ferr_q, ferr_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  // Only the IDLE start-edge detect acts without a tick; every other move
  // waits for sample_tick so the counters stay in bit-period units.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (sample_tick) begin
          if (s_q == S_HALF) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (sample_tick) begin
          if (s_q == S_BIT) begin
            shreg_d = {rx_s, shreg_q[DBITS-1:1]};
            s_d     = '0;
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      STOP: begin
        if (sample_tick) begin
          if (s_q == S_STOP) begin
            data_d  = shreg_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign data_out     = data_q;
  assign frame_error  = ferr_q;
  assign rx_done_tick = done_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: tick every 4 clk (64 clk per bit),
// directed scenarios followed by random frames checked against a frame model.
module tb_uart_receiver;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  data_out;
  logic        rx_done_tick;
  logic        frame_error;
  uart_state_e state_dbg;

  logic tick_en = 1'b1;
  int   tick_cnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  int   exp_done = 0;

  // expected frames: {frame_error, data}
  logic [8:0] exp_q[$];

  uart_receiver dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx          (rx),
    .data_out    (data_out),
    .rx_done_tick(rx_done_tick),
    .frame_error (frame_error),
    .state_dbg   (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      sample_tick = tick_en && ((tick_cnt % 4) == 3);
      tick_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clks(64);
  endtask

  // A frame with a low stop bit releases the line partway through the stop
  // bit and then idles a full bit so the false start that follows is rejected.
  task automatic send_frame(input logic [7:0] d, input logic stop_hi);
    exp_q.push_back({~stop_hi, d});
    exp_done++;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (stop_hi) begin
      send_bit(1'b1);
    end else begin
      rx = 1'b0;
      wait_clks(40);
      rx = 1'b1;
      wait_clks(24 + 64);
    end
  endtask

  task automatic drain();
    int i = 0;
    while (exp_q.size() > 0 && i < 3000) begin
      wait_clks(1);
      i++;
    end
    wait_clks(2);
    check("drain_empty", exp_q.size(), 0);
    check("done_count", done_cnt, exp_done);
  endtask

  // scoreboard monitor
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rx_done_tick === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("data_out", data_out, e[7:0]);
          check("frame_error", frame_error, e[8]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic       sb;

    // reset state
    reset = 1'b1;
    rx    = 1'b1;
    wait_clks(3);
    check("rst_data", data_out, 0);
    check("rst_ferr", frame_error, 0);
    check("rst_done", rx_done_tick, 0);
    check("rst_state", state_dbg, IDLE);
    reset = 1'b0;
    wait_clks(10);
    check("idle_after_rst", state_dbg, IDLE);

    // 1: clean frame
    send_frame(8'hA5, 1'b1);
    drain();
    wait_clks(100);
    check("hold_a5", data_out, 8'hA5);

    // 2: short glitch rejected
    rx = 1'b0;
    wait_clks(20);
    rx = 1'b1;
    wait_clks(200);
    check("glitch_done", done_cnt, exp_done);
    check("glitch_data", data_out, 8'hA5);
    check("glitch_state", state_dbg, IDLE);

    // 3: framing error then recovery
    send_frame(8'h3C, 1'b0);
    drain();
    check("ferr_held", frame_error, 1);
    send_frame(8'h11, 1'b1);
    drain();
    check("ferr_clear", frame_error, 0);

    // 4: reset during data bit 3 of 0xFF
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx = 1'b1;
    wait_clks(32);
    reset = 1'b1;
    wait_clks(3);
    check("midrst_data", data_out, 0);
    check("midrst_ferr", frame_error, 0);
    check("midrst_state", state_dbg, IDLE);
    reset = 1'b0;
    wait_clks(700);
    check("midrst_nodone", done_cnt, exp_done);
    send_frame(8'h5A, 1'b1);
    drain();

    // 5: back-to-back frames
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    rx = 1'b1;
    drain();

    // 6: frozen ticks after start detect
    wait_clks(50);
    tick_en = 1'b0;
    rx = 1'b0;
    wait_clks(10);
    check("freeze_start", state_dbg, START);
    for (int i = 0; i < 25; i++) begin
      rx = 1'($urandom_range(0, 1));
      wait_clks(4);
    end
    check("freeze_hold", state_dbg, START);
    check("freeze_nodone", done_cnt, exp_done);
    rx = 1'b0;
    tick_en = 1'b1;
    send_frame(8'h81, 1'b1);
    rx = 1'b1;
    drain();
    check("resume_data", data_out, 8'h81);

    // random frames with random stop level and idle gaps
    for (int k = 0; k < 10; k++) begin
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      send_frame(d, sb);
      rx = 1'b1;
      wait_clks($urandom_range(0, 80));
    end
    drain();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
